// File: rtl/fifo_120b.sv
// fifo_120b: 15 x 8-bit single-clock FIFO for PCM audio samples.
// Registered read port, count/full/empty status, overflow/underflow pulses.
module fifo_120b #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 15,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULLV = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [1:0]            rsync;
  logic                  rst_n;
  logic                  wen;
  logic                  ren;

  // Assert immediately, release two edges after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rsync <= 2'b00;
    else        rsync <= {rsync[0], 1'b1};
  end

  assign rst_n = rsync[1];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULLV);

  // When full, a concurrent read frees the slot the write lands in.
  assign ren = rd & ~empty;
  assign wen = wr & (~full | rd);

  always_ff @(posedge clk) begin
    if (wen) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr & ~wen;
      underflow <= rd & ~ren;
      if (wen) wptr <= nxt(wptr);
      if (ren) begin
        rptr <= nxt(rptr);
        dout <= mem[rptr];
      end
      unique case (1'b1)
        wen & ~ren: count <= count + 1'b1;
        ren & ~wen: count <= count - 1'b1;
        default:    count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_120b.sv
// tb_fifo_120b: directed vector table plus corner sequences
// for the 15-entry byte FIFO.
module tb_fifo_120b;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t tbl[80];
  int   n = 0;

  fifo_120b dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .din(din),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr = w;
    rd = r;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic w, input logic r, input logic [7:0] d,
                     input logic [7:0] o, input int c, input logic e,
                     input logic f, input logic ov, input logic un);
    tbl[n] = '{w, r, d, o, 4'(c), e, f, ov, un};
    n++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill 0x01..0x10: sixteenth write dropped.
    for (int i = 0; i < 16; i++)
      add(1, 0, 8'(i + 1), 8'h00, (i < 15) ? i + 1 : 15,
          0, i >= 14, i == 15, 0);
    add(0, 0, 8'h00, 8'h00, 15, 0, 1, 0, 0);
    // Drain: sixteenth read underflows, dout holds 0x0F.
    for (int i = 0; i < 16; i++)
      add(0, 1, 8'h00, (i < 15) ? 8'(i + 1) : 8'h0F,
          (i < 15) ? 14 - i : 0, i >= 14, 0, 0, i == 15);
    add(0, 0, 8'h00, 8'h0F, 0, 1, 0, 0, 0);
    // Simultaneous on empty: write only, read rejected.
    add(1, 1, 8'h55, 8'h0F, 1, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++)
      add(1, 0, 8'(8'h60 + i), 8'h0F, i + 2, 0, i == 13, 0, 0);
    // Simultaneous on full: oldest out, 0x77 in.
    add(1, 1, 8'h77, 8'h55, 15, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++)
      add(0, 1, 8'h00, (i < 14) ? 8'(8'h60 + i) : 8'h77,
          14 - i, i == 14, 0, 0, 0);

    do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_ov", 32'(overflow), 0);
    chk("rst_un", 32'(underflow), 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < n; i++) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].count));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].full));
      chk($sformatf("v%0d_ov", i), 32'(overflow), 32'(tbl[i].ov));
      chk($sformatf("v%0d_un", i), 32'(underflow), 32'(tbl[i].un));
    end

    // Wrap: two 10-byte bursts cross the pointer boundary.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) begin
        cyc(1, 0, 8'((b == 0 ? 8'hA0 : 8'hB0) + i));
        chk("wrap_wcount", 32'(count), 32'(i + 1));
      end
      for (int i = 0; i < 10; i++) begin
        cyc(0, 1, 8'h00);
        chk("wrap_dout", 32'(dout), 32'((b == 0 ? 8'hA0 : 8'hB0) + i));
        chk("wrap_rcount", 32'(count), 32'(9 - i));
      end
      chk("wrap_empty", 32'(empty), 1);
    end

    // Long hold: only the first 15 bytes survive.
    for (int i = 0; i < 100; i++) begin
      cyc(1, 0, 8'(i));
      chk("hold_ov", 32'(overflow), 32'(i >= 15));
    end
    chk("hold_full", 32'(full), 1);
    chk("hold_count", 32'(count), 15);
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1, 8'h00);
      chk("hold_dout", 32'(dout), 32'((i < 15) ? i : 14));
      chk("hold_un", 32'(underflow), 32'(i >= 15));
    end
    cyc(0, 0, 8'h00);
    chk("hold_empty", 32'(empty), 1);
    chk("hold_full0", 32'(full), 0);
    chk("hold_un0", 32'(underflow), 0);

    // Asynchronous reset mid-stream with seven entries.
    for (int i = 0; i < 7; i++) cyc(1, 0, 8'(8'hC0 + i));
    cyc(0, 0, 8'h00);
    chk("mid_count7", 32'(count), 7);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_count0", 32'(count), 0);
    chk("mid_empty", 32'(empty), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc(1, 0, 8'h3C);
    cyc(0, 1, 8'h00);
    chk("post_rst_dout", 32'(dout), 32'h3C);
    chk("post_rst_empty", 32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_120b.md
Name: fifo_120b

Overview:
- Synchronous single-clock byte FIFO: 15 entries x 8 bits, 120 bits of storage in total.
- Buffers 8-bit PCM audio samples between the microphone sampler (writer) and the downstream consumer (reader).
- Provides a registered read port, full/empty/count status, and one-cycle overflow/underflow error pulses.

Parameters:
- DATA_WIDTH, 8, width of din/dout in bits.
- DEPTH, 15, number of storage entries; must be at least 2; does not need to be a power of two.
- CNT_WIDTH, 4, width of count; must satisfy 2^CNT_WIDTH > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr  input  1  write request, sampled on each rising clk edge; may be held high for many cycles.
- rd  input  1  read request, sampled on each rising clk edge; may be held high for many cycles.
- din  input  DATA_WIDTH  write data, captured when a write is accepted.
- dout  output  DATA_WIDTH  registered read data.
- empty  output  1  high when count==0.
- full  output  1  high when count==DEPTH.
- count  output  CNT_WIDTH  number of entries currently stored.
- overflow  output  1  one-cycle pulse when a write is rejected.
- underflow  output  1  one-cycle pulse when a read is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - Write and read pointers and count go to 0; dout=0; empty=1; full=0; overflow=0; underflow=0.
  - Storage array contents are not cleared and are don't-care.
  - Deassertion is synchronized to clk by the usual two-flop release.
- Accepted write (wr=1 and not full):
  - mem[wptr] <= din.
  - wptr increments, wrapping from DEPTH-1 to 0.
- Accepted read (rd=1 and not empty):
  - dout <= mem[rptr]; data is visible the cycle after the rd edge (1-cycle latency).
  - rptr increments, wrapping from DEPTH-1 to 0.
  - dout holds its last value whenever no read is accepted.
- Continuous wr or rd: one transfer per clock cycle while the request is held and the relevant condition (not full / not empty) holds.
- Rejected write (wr=1 and full, no simultaneous accepted read): storage, pointers and count are unchanged; overflow=1 for that cycle.
- Rejected read (rd=1 and empty): dout, pointers and count are unchanged; underflow=1 for that cycle.
- Simultaneous wr=1, rd=1:
  - Empty: the write is accepted and the read is rejected (underflow pulse); count becomes 1. No fall-through.
  - Full: both are accepted; oldest entry is read out, new entry written into the freed slot; count stays DEPTH, full stays 1, no overflow.
  - Otherwise: both are accepted; count is unchanged.
- Count update per cycle: +1 on write-only, -1 on read-only, unchanged otherwise.
- Flags: empty and full are decoded combinationally from the registered count, so both are valid in the same cycle count changes.
- Ordering: data is read out in strict first-in, first-out order across any number of pointer wraps.
- X handling: din may be X while wr=0; X on din is never written into storage.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> empty=1, full=0, count=0, dout=0x00. Assert reset mid-stream with count=7 -> count=0 and empty=1 immediately, without waiting for a clk edge.
- Fill: after reset, hold wr=1 for 16 cycles with din=0x01..0x10 -> full=1 after the 15th write, count=15. The 16th write (0x10) is dropped and overflow pulses for exactly 1 cycle.
- Drain: from full, hold rd=1 for 16 cycles -> dout=0x01..0x0F in order, each 1 cycle after its rd edge. empty=1 after the 15th read. The 16th read pulses underflow and dout stays 0x0F.
- Wrap: write 10 bytes then read 10, twice (values 0xA0..0xA9, then 0xB0..0xB9) -> pointers cross DEPTH-1 to 0; output order exact; count returns to 0 after each burst.
- Simultaneous access:
  - Empty, wr=rd=1 with din=0x55 -> count=1, underflow=1, dout unchanged.
  - Full, wr=rd=1 with din=0x77 -> oldest byte on dout, count=15, no overflow; 0x77 emerges last on the next full drain.
- Long hold: wr=1 for 100 cycles with rd=0, then rd=1 for 100 cycles -> only the first 15 bytes are stored and read back; no corruption; flags settle to empty=1.
